// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: opcode/handshake inputs and control/status outputs between the
// multicycle control unit (master) and its datapath (slave).
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic             MemRdy;
    logic             RegWr, MemRd, MemWr, RegDst, MemtoReg;
    logic             IRWr, IorD, PCWr, PCWrCond, ALUSrcA;
    logic [1:0]       PCSrc, ALUOp, ALUSrcB;
    logic             BrInv;
    logic [3:0]       State;
    logic             Illegal, Halted;
    logic [CNT_W-1:0] InstCnt;
    modport master (
        input  Op, MemRdy,
        output RegWr, MemRd, MemWr, RegDst, MemtoReg, IRWr, IorD, PCWr, PCWrCond,
               ALUSrcA, PCSrc, ALUOp, ALUSrcB, BrInv, State, Illegal, Halted, InstCnt
    );
    modport slave (
        output Op, MemRdy,
        input  RegWr, MemRd, MemWr, RegDst, MemtoReg, IRWr, IorD, PCWr, PCWrCond,
               ALUSrcA, PCSrc, ALUOp, ALUSrcB, BrInv, State, Illegal, Halted, InstCnt
    );
endinterface

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle control FSM with memory-wait timeout, trap state and retired count.
// Defining MC_CTRL_BNE_EN adds bne (opcode 000101) as a branch on inverted Zero.
module mc_ctrl_unit #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input logic       Clock,
    input logic       Reset,
    mc_ctrl_if.master bus
);
    localparam int WW = $clog2(WAIT_MAX + 2);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB,
        BRANCH, JUMP, ADDIEX, ADDIWB, TRAP
    } state_t;
    state_t           state, nxt;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] inst_cnt;
    logic             illegal, bne, bne_op, bad_op, waiting, timeout;
`ifdef MC_CTRL_BNE_EN
    assign bne_op = bus.Op == 6'b000101;
`else
    assign bne_op = 1'b0;
`endif
    assign waiting = state == FETCH || state == MEMRD || state == MEMWR;
    assign timeout = WAIT_MAX != 0 && waiting && !bus.MemRdy && wait_cnt == WW'(WAIT_MAX);
    always_comb begin
        nxt    = TRAP;
        bad_op = 1'b0;
        case (state)
            FETCH:   nxt = timeout ? TRAP : bus.MemRdy ? DECODE : FETCH;
            DECODE:
                case (bus.Op)
                    6'b000000:            nxt = EXEC;
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000100:            nxt = BRANCH;
                    6'b000010:            nxt = JUMP;
                    6'b001000:            nxt = ADDIEX;
                    default: begin
                        nxt    = bne_op ? BRANCH : TRAP;
                        bad_op = !bne_op;
                    end
                endcase
            MEMADR:  nxt = bus.Op == 6'b101011 ? MEMWR : MEMRD;
            MEMRD:   nxt = timeout ? TRAP : bus.MemRdy ? MEMWB : MEMRD;
            MEMWR:   nxt = timeout ? TRAP : bus.MemRdy ? FETCH : MEMWR;
            EXEC:    nxt = RWB;
            ADDIEX:  nxt = ADDIWB;
            MEMWB, RWB, BRANCH, JUMP, ADDIWB: nxt = FETCH;
            default: nxt = TRAP;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            inst_cnt <= '0;
            illegal  <= 1'b0;
            bne      <= 1'b0;
        end else begin
            state    <= nxt;
            wait_cnt <= nxt != state ? '0 : wait_cnt + WW'(waiting && !bus.MemRdy);
            inst_cnt <= inst_cnt + CNT_W'(nxt == FETCH && state != FETCH);
            illegal  <= illegal | bad_op;
            if (state == DECODE) bne <= bne_op;
        end
    end
    // Decoded from state alone; only the FETCH write enables follow MemRdy.
    always_comb begin
        bus.RegWr    = 1'b0;
        bus.MemRd    = 1'b0;
        bus.MemWr    = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.IRWr     = 1'b0;
        bus.IorD     = 1'b0;
        bus.PCWr     = 1'b0;
        bus.PCWrCond = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.PCSrc    = 2'b00;
        bus.ALUOp    = 2'b00;
        bus.ALUSrcB  = 2'b00;
        case (state)
            FETCH: begin
                bus.MemRd   = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWr    = bus.MemRdy;
                bus.PCWr    = bus.MemRdy;
            end
            DECODE:  bus.ALUSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD: begin
                bus.MemRd = 1'b1;
                bus.IorD  = 1'b1;
            end
            MEMWB: begin
                bus.RegWr    = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEMWR: begin
                bus.MemWr = 1'b1;
                bus.IorD  = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            RWB: begin
                bus.RegWr  = 1'b1;
                bus.RegDst = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = 2'b01;
                bus.PCWrCond = 1'b1;
                bus.PCSrc    = 2'b01;
            end
            JUMP: begin
                bus.PCWr  = 1'b1;
                bus.PCSrc = 2'b10;
            end
            ADDIWB:  bus.RegWr = 1'b1;
            default: ;
        endcase
    end
    assign bus.BrInv   = state == BRANCH && bne;
    assign bus.State   = state;
    assign bus.Illegal = illegal;
    assign bus.Halted  = state == TRAP;
    assign bus.InstCnt = inst_cnt;
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: random instruction streams with random memory stalls against an
// instruction-level model that predicts each cycle's state and control word.
module tb_mc_ctrl_unit;
    localparam int CW = 3;
    localparam int WM = 4;
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9,
                   S_ADDIEX = 10, S_ADDIWB = 11, S_TRAP = 12;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   m_cnt = 0;
    logic m_ill = 1'b0;
    logic m_bne = 1'b0;
    logic [5:0] ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd5, 6'd63};
    mc_ctrl_if #(.CNT_W(CW)) bus();
    mc_ctrl_unit #(.CNT_W(CW), .WAIT_MAX(WM)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
    always #5 Clock = ~Clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic r();
        return 1'($urandom);
    endfunction
    function automatic logic [17:0] ctl_now();
        return {bus.RegWr, bus.MemRd, bus.MemWr, bus.RegDst, bus.MemtoReg, bus.IRWr, bus.IorD,
                bus.PCWr, bus.PCWrCond, bus.ALUSrcA, bus.PCSrc, bus.ALUOp, bus.ALUSrcB,
                bus.BrInv, bus.Halted};
    endfunction
    function automatic logic [17:0] exp_ctl(input int st, input logic rdy);
        logic rw, mr, mw, rd, m2r, irw, iod, pcw, pcc, asa, bi, h;
        logic [1:0] pcs, aop, asb;
        {rw, mr, mw, rd, m2r, irw, iod, pcw, pcc, asa, bi, h} = '0;
        {pcs, aop, asb} = '0;
        case (st)
            S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mr = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mw = 1; iod = 1; end
            S_EXEC:   begin asa = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; rd = 1; end
            S_BRANCH: begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; bi = m_bne; end
            S_JUMP:   begin pcw = 1; pcs = 2'b10; end
            S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_ADDIWB: rw = 1;
            S_TRAP:   h = 1;
            default:  ;
        endcase
        return {rw, mr, mw, rd, m2r, irw, iod, pcw, pcc, asa, pcs, aop, asb, bi, h};
    endfunction
    task automatic cyc(input logic [5:0] op, input logic rdy, input int st);
        bus.Op = op;
        bus.MemRdy = rdy;
        #4;
        check("state", bus.State, st);
        check("ctrl", ctl_now(), exp_ctl(st, rdy));
        check("illegal", bus.Illegal, m_ill);
        @(posedge Clock);
        #1;
    endtask
    task automatic do_reset(input logic rdy);
        Reset = 1'b1;
        bus.Op = 6'($urandom);
        bus.MemRdy = rdy;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        m_cnt = 0;
        m_ill = 1'b0;
        m_bne = 1'b0;
        check("rst_state", bus.State, S_FETCH);
        check("rst_cnt", bus.InstCnt, 0);
        check("rst_ill", bus.Illegal, 0);
        check("rst_halt", bus.Halted, 0);
    endtask
    task automatic trap_phase();
        for (int i = 0; i < 3; i++) cyc(6'($urandom), r(), S_TRAP);
        do_reset(r());
    endtask
    // w stall cycles then one ready cycle; more than WM stalls must end in TRAP.
    task automatic mem_phase(input logic [5:0] op, input int st, input int w, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i <= w; i++) begin
            cyc(op, i == w, st);
            if (i != w && i == WM) begin
                trapped = 1'b1;
                return;
            end
        end
    endtask
    task automatic do_inst(input logic [5:0] op, input int fw, input int mw);
        bit t;
        mem_phase(op, S_FETCH, fw, t);
        if (t) begin
            trap_phase();
            return;
        end
        cyc(op, r(), S_DECODE);
        case (op)
            6'b000000: begin cyc(op, r(), S_EXEC); cyc(op, r(), S_RWB); end
            6'b100011, 6'b101011: begin
                cyc(op, r(), S_MEMADR);
                mem_phase(op, op == 6'b100011 ? S_MEMRD : S_MEMWR, mw, t);
                if (t) begin
                    trap_phase();
                    return;
                end
                if (op == 6'b100011) cyc(op, r(), S_MEMWB);
            end
            6'b000100: cyc(op, r(), S_BRANCH);
`ifdef MC_CTRL_BNE_EN
            6'b000101: begin m_bne = 1'b1; cyc(op, r(), S_BRANCH); m_bne = 1'b0; end
`endif
            6'b000010: cyc(op, r(), S_JUMP);
            6'b001000: begin cyc(op, r(), S_ADDIEX); cyc(op, r(), S_ADDIWB); end
            default: begin
                m_ill = 1'b1;
                trap_phase();
                return;
            end
        endcase
        m_cnt = (m_cnt + 1) % (1 << CW);
        check("inst_cnt", bus.InstCnt, m_cnt);
    endtask
    function automatic logic [5:0] rand_op();
        int k = $urandom_range(0, 9);
        return k < 8 ? ops[k] : 6'($urandom);
    endfunction
    function automatic int rand_wait();
        return $urandom_range(0, 11) == 0 ? WM + 1 : int'($urandom_range(0, 3));
    endfunction
    initial begin
        bus.Op = '0;
        bus.MemRdy = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) do_inst(ops[i], 0, 0);
        check("seq_cnt6", bus.InstCnt, 6);
        do_inst(6'd35, 0, 3);
        do_inst(6'd0, 1, 0);
        do_inst(6'd8, 2, 0);
        check("wrap_cnt1", bus.InstCnt, 1);
        cyc(6'd35, 1'b1, S_FETCH);
        cyc(6'd35, r(), S_DECODE);
        cyc(6'd35, r(), S_MEMADR);
        check("pre_rst_memrd", bus.State, S_MEMRD);
        do_reset(1'b1);
        do_inst(6'd43, 0, 0);
        cyc(6'd0, 1'b1, S_FETCH);
        cyc(6'd0, r(), S_DECODE);
        cyc(6'd0, r(), S_EXEC);
        check("pre_rst_rwb", bus.State, S_RWB);
        do_reset(1'b1);
        do_inst(6'd0, WM + 1, 0);
        do_inst(6'd63, 0, 0);
        do_inst(6'd5, 0, 0);
        do_inst(6'd4, 0, 0);
        do_inst(6'd35, 0, WM + 1);
        do_inst(6'd43, 1, WM);
        for (int n = 0; n < 300; n++) do_inst(rand_op(), rand_wait(), rand_wait());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 The block SHALL have parameter WAIT_MAX, default 15: maximum memory wait cycles before trap; 0 disables the timeout.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Op, input, 6 bits: opcode Inst[31:26] from the IR.
REQ-006 The block SHALL have port MemRdy, input, 1 bit: memory completes the current access this cycle.
REQ-007 The block SHALL have control outputs RegWr, MemRd, MemWr, RegDst, MemtoReg, IRWr, IorD, PCWr, PCWrCond and ALUSrcA, 1 bit each, with the existing datapath meanings.
REQ-008 The block SHALL have outputs PCSrc, ALUOp and ALUSrcB, 2 bits each, with the existing datapath encodings.
REQ-009 The block SHALL have port BrInv, output, 1 bit: the datapath inverts Zero before the PCWrCond AND.
REQ-010 The block SHALL have port State, output, 4 bits: current FSM state.
REQ-011 The block SHALL have outputs Illegal and Halted, 1 bit each: trap cause and trap status.
REQ-012 The block SHALL have port InstCnt, output, CNT_W bits: count of retired instructions.

Function
REQ-013 The FSM SHALL use these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12; codes 13-15 SHALL go to TRAP.
REQ-014 All outputs SHALL be decoded from State alone, except IRWr and PCWr in FETCH; any output not listed for a state SHALL be 0.
REQ-015 FETCH SHALL drive MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, and SHALL assert IRWr=PCWr=1 only in the cycle MemRdy=1, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-016 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and branch on Op: 000000 to EXEC, 100011 or 101011 to MEMADR, 000100 to BRANCH, 000010 to JUMP, 001000 to ADDIEX; any other opcode SHALL go to TRAP and set Illegal.
REQ-017 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-018 MEMRD SHALL drive MemRd=1, IorD=1, holding until MemRdy=1, then go to MEMWB.
REQ-019 MEMWB SHALL drive RegWr=1, MemtoReg=1, RegDst=0.
REQ-020 MEMWR SHALL drive MemWr=1, IorD=1, holding until MemRdy=1, then go to FETCH.
REQ-021 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB; RWB SHALL drive RegWr=1, RegDst=1, MemtoReg=0.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWrCond=1, PCSrc=01.
REQ-023 JUMP SHALL drive PCWr=1, PCSrc=10.
REQ-024 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB; ADDIWB SHALL drive RegWr=1, RegDst=0, MemtoReg=0.
REQ-025 MEMWB, RWB, BRANCH, JUMP and ADDIWB SHALL return to FETCH unconditionally.
REQ-026 Latencies with MemRdy always 1 SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
REQ-027 InstCnt SHALL increment by 1 on each transition into FETCH from any state other than FETCH, wrapping modulo 2^CNT_W.
REQ-028 A wait counter SHALL clear on every state change and increment on each cycle spent in FETCH, MEMRD or MEMWR with MemRdy=0.
REQ-029 When WAIT_MAX is nonzero and the wait counter equals WAIT_MAX with MemRdy=0, the next state SHALL be TRAP, with Illegal=0.
REQ-030 In TRAP, Halted SHALL be 1 and all control outputs SHALL be 0; the FSM SHALL remain in TRAP until Reset.
REQ-031 Illegal SHALL be sticky until Reset.

Reset
REQ-032 When Reset=1 at a rising edge, the block SHALL set State=FETCH, InstCnt=0, Illegal=0, Halted=0 and the wait counter to 0, regardless of the current state, including TRAP or mid-access.
REQ-033 Reset SHALL dominate MemRdy and every other input on the same edge, and InstCnt SHALL NOT increment on that edge.

Configuration
REQ-034 With macro MC_CTRL_BNE_EN defined, opcode 000101 SHALL decode in DECODE to BRANCH, with BrInv=1 while in BRANCH for that instruction only.
REQ-035 Without MC_CTRL_BNE_EN, opcode 000101 SHALL be illegal and BrInv SHALL be constant 0.

Verification
REQ-036 Reset then sequence R, lw, sw, beq, j, addi with MemRdy=1 -> cycle counts 4/5/4/3/3/4, and InstCnt=6 on reentry to FETCH.
REQ-037 lw with MemRdy low for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRd=IorD=1, MEMWB reached, and RegWr pulses exactly once.
REQ-038 WAIT_MAX=4 with MemRdy=0 held in FETCH -> TRAP on the 6th cycle, Halted=1, Illegal=0, and IRWr never asserted.
REQ-039 Op=111111 in DECODE -> TRAP next cycle with Illegal=1; Reset pulse -> State=0 and Illegal=0.
REQ-040 Op=000101 -> with MC_CTRL_BNE_EN: BRANCH state with BrInv=1 and PCWrCond=1; without it: TRAP with Illegal=1.
REQ-041 CNT_W=3 with 9 retired instructions, and Reset asserted while in MEMRD -> InstCnt=1 after wrap, and FETCH with InstCnt=0 after the reset edge.
